// File: rtl/game_timer_ctrl.sv
// Run/pause/done controller for a BCD stopwatch. Start/clear come from the SoC PIO,
// a debounced push button, or USB keycodes; every output is registered.
module game_timer_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [7:0]  START_KEY       = 8'h28,
  parameter logic [7:0]  PAUSE_KEY       = 8'h2C,
  parameter logic [15:0] LIMIT_BCD       = 16'h9959
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_sw,
  input  logic        reset_sw,
  input  logic        key_n,
  input  logic [7:0]  keycode,
  input  logic [15:0] time_bcd,
  output logic        sw_run,
  output logic        sw_reset,
  output logic [1:0]  state,
  output logic        done,
  output logic [7:0]  pause_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    DONE    = 2'b11
  } state_t;

  logic          sync1_reg, sync2_reg;
  logic          db_level_reg;
  logic [CW-1:0] db_cnt_reg;
  logic          start_prev_reg, clr_prev_reg;
  logic [7:0]    kc_prev_reg;

  state_t        state_reg, state_next;
  logic          sw_run_reg, sw_run_next;
  logic          sw_reset_reg, sw_reset_next;
  logic          done_reg, done_next;
  logic [7:0]    pause_count_reg, pause_count_next;

  logic btn_evt, start_evt, clr_evt, key_start_evt, key_pause_evt;
  logic toggle, limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg      <= 1'b1;
      sync2_reg      <= 1'b1;
      db_level_reg   <= 1'b1;
      db_cnt_reg     <= '0;
      start_prev_reg <= 1'b0;
      clr_prev_reg   <= 1'b0;
      kc_prev_reg    <= 8'h00;
    end else begin
      sync1_reg      <= key_n;
      sync2_reg      <= sync1_reg;
      start_prev_reg <= start_sw;
      clr_prev_reg   <= reset_sw;
      kc_prev_reg    <= keycode;
      // Any cycle where the synchronized input agrees with the debounced level restarts the count
      if (sync2_reg != db_level_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          db_level_reg <= sync2_reg;
          db_cnt_reg   <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  // Press event fires in the same cycle the debounced level is about to fall
  assign btn_evt       = db_level_reg & ~sync2_reg & (db_cnt_reg == DB_LAST);
  assign start_evt     = start_sw & ~start_prev_reg;
  assign clr_evt       = reset_sw & ~clr_prev_reg;
  assign key_start_evt = (keycode == START_KEY) && (kc_prev_reg != keycode);
  assign key_pause_evt = (keycode == PAUSE_KEY) && (kc_prev_reg != keycode);
  assign toggle        = start_evt | btn_evt | key_start_evt;
  assign limit         = (state_reg == RUNNING) && (time_bcd == LIMIT_BCD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      sw_run_reg      <= 1'b0;
      sw_reset_reg    <= 1'b1;
      done_reg        <= 1'b0;
      pause_count_reg <= 8'h00;
    end else begin
      state_reg       <= state_next;
      sw_run_reg      <= sw_run_next;
      sw_reset_reg    <= sw_reset_next;
      done_reg        <= done_next;
      pause_count_reg <= pause_count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clr_evt) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (toggle) state_next = RUNNING;
        RUNNING: begin
          if (limit)                        state_next = DONE;
          else if (toggle || key_pause_evt) state_next = PAUSED;
        end
        PAUSED:  if (toggle) state_next = RUNNING;
        default: state_next = state_reg;
      endcase
    end
  end

  // Registered outputs are computed from the next state so they move on the command edge
  always_comb begin
    sw_run_next      = (state_next == RUNNING);
    done_next        = (state_next == DONE);
    sw_reset_next    = clr_evt;
    pause_count_next = pause_count_reg;
    if (clr_evt) begin
      pause_count_next = 8'h00;
    end else if (state_reg == RUNNING && state_next == PAUSED && pause_count_reg != 8'hFF) begin
      pause_count_next = pause_count_reg + 8'h01;
    end
  end

  assign state       = state_reg;
  assign sw_run      = sw_run_reg;
  assign sw_reset    = sw_reset_reg;
  assign done        = done_reg;
  assign pause_count = pause_count_reg;

endmodule
